// File: rtl/cache_sram_bank.sv
// rtl/cache_sram_bank.sv - multi-way byte-masked SRAM bank with write-first read and post-reset clear
// Registered read port holds rdata when idle; init sequencer zeroes every entry after reset.
module cache_sram_bank #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_LEN = 6,
  parameter int WAYS = 2,
  localparam int DEPTH = 2 ** ADDR_LEN,
  localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       init_busy,
  input  logic                       ren,
  input  logic [ADDR_LEN-1:0]        raddr,
  input  logic [WAYS-1:0]            we,
  input  logic [ADDR_LEN-1:0]        waddr,
  input  logic [MASK_WIDTH-1:0]      wmask,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic [WAYS*DATA_WIDTH-1:0] rdata,
  output logic                       rvalid
);

  typedef enum logic {S_INIT, S_READY} state_t;

  localparam logic [ADDR_LEN:0] INIT_LAST = (ADDR_LEN + 1)'(DEPTH - 1);

  state_t                state;
  logic [ADDR_LEN:0]     init_cnt;
  logic [DATA_WIDTH-1:0] mem [WAYS][DEPTH];
  logic [DATA_WIDTH-1:0] merged [WAYS];
  logic [WAYS*DATA_WIDTH-1:0] rd_next;

  // merged is the post-write row at waddr; a same-index read picks it up (write-first)
  always_comb begin
    rd_next = '0;
    for (int w = 0; w < WAYS; w++) begin
      merged[w] = mem[w][waddr];
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (wmask[b]) merged[w][8*b +: 8] = wdata[8*b +: 8];
      end
      if (we[w] && (raddr == waddr)) rd_next[w*DATA_WIDTH +: DATA_WIDTH] = merged[w];
      else                           rd_next[w*DATA_WIDTH +: DATA_WIDTH] = mem[w][raddr];
    end
  end

  // storage has no reset of its own; the INIT state clears it instead
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_INIT) begin
        for (int w = 0; w < WAYS; w++) mem[w][init_cnt[ADDR_LEN-1:0]] <= '0;
      end else begin
        for (int w = 0; w < WAYS; w++) begin
          if (we[w]) mem[w][waddr] <= merged[w];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      init_busy <= 1'b1;
      rdata     <= '0;
      rvalid    <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          rvalid   <= 1'b0;
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == INIT_LAST) begin
            init_busy <= 1'b0;
            state     <= S_READY;
          end
        end
        default: begin
          rvalid <= ren;
          if (ren) rdata <= rd_next;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_sram_bank.sv
// tb/tb_cache_sram_bank.sv - randomized self-checking bench for cache_sram_bank
// Reference model is a plain per-way array updated byte by byte before each read is evaluated.
module tb_cache_sram_bank;

  localparam int DW = 128;
  localparam int AL = 6;
  localparam int W = 2;
  localparam int DEPTH = 64;
  localparam int MW = DW / 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            init_busy;
  logic            ren = 1'b0;
  logic [AL-1:0]   raddr = '0;
  logic [W-1:0]    we = '0;
  logic [AL-1:0]   waddr = '0;
  logic [MW-1:0]   wmask = '0;
  logic [DW-1:0]   wdata = '0;
  logic [W*DW-1:0] rdata;
  logic            rvalid;

  int total = 0;
  int bad = 0;

  logic [DW-1:0]   model [W][DEPTH];
  logic [W*DW-1:0] exp_hold;

  cache_sram_bank #(.DATA_WIDTH(DW), .ADDR_LEN(AL), .WAYS(W)) dut (
    .clk(clk), .reset(reset), .init_busy(init_busy), .ren(ren), .raddr(raddr),
    .we(we), .waddr(waddr), .wmask(wmask), .wdata(wdata), .rdata(rdata), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ren = 1'b0; we = '0; wmask = '0; wdata = '0; raddr = '0; waddr = '0;
  endtask

  task automatic model_clear();
    for (int w = 0; w < W; w++)
      for (int i = 0; i < DEPTH; i++) model[w][i] = '0;
  endtask

  task automatic model_write(input logic [W-1:0] wv, input logic [AL-1:0] a,
                             input logic [MW-1:0] m, input logic [DW-1:0] d);
    for (int w = 0; w < W; w++)
      if (wv[w])
        for (int b = 0; b < MW; b++)
          if (m[b]) model[w][a][8*b +: 8] = d[8*b +: 8];
  endtask

  function automatic logic [W*DW-1:0] model_row(input logic [AL-1:0] a);
    logic [W*DW-1:0] r;
    for (int w = 0; w < W; w++) r[w*DW +: DW] = model[w][a];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // counts edges until init_busy drops; also counts any rvalid seen meanwhile
  task automatic wait_init(output int edges, output int valids);
    edges = 0; valids = 0;
    do begin
      step();
      edges++;
      if (rvalid) valids++;
    end while (init_busy && edges < 200);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) step();
    total++; if (init_busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", init_busy); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", rvalid); end
    total++; if (rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
  endtask

  // requests are held active during the clear and must be ignored
  task automatic test_init_ignore();
    int edges, valids;
    reset = 1'b0;
    ren = 1'b1; raddr = '0; we = '1; waddr = '0; wmask = '1; wdata = '1;
    wait_init(edges, valids);
    idle_inputs();
    model_clear();
    total++; if (edges !== DEPTH) begin bad++; $display("FAIL init_length got=%0d want=%0d", edges, DEPTH); end
    total++; if (valids !== 0) begin bad++; $display("FAIL init_rvalid got=%0d want=0", valids); end
  endtask

  task automatic test_init_reads();
    for (int i = 0; i < DEPTH; i++) begin
      ren = 1'b1; raddr = AL'(i);
      step();
      total++;
      if (rvalid !== 1'b1 || rdata !== '0) begin
        bad++; $display("FAIL init_read idx=%0d got=%h/%b want=0/1", i, rdata, rvalid);
      end
    end
    ren = 1'b0;
  endtask

  task automatic test_byte_mask();
    logic [W*DW-1:0] want;
    we = 2'b01; waddr = 6'd5; wmask = '1; wdata = '1;
    model_write(we, waddr, wmask, wdata);
    step();
    wmask = 16'h0001; wdata = {MW{8'h11}};
    model_write(we, waddr, wmask, wdata);
    step();
    we = '0; ren = 1'b1; raddr = 6'd5;
    step();
    ren = 1'b0;
    want = {{DW{1'b0}}, {15{8'hFF}}, 8'h11};
    total++; if (rdata !== want) begin bad++; $display("FAIL byte_mask got=%h want=%h", rdata, want); end
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL byte_mask_rvalid got=%b want=1", rvalid); end
    step();
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL byte_mask_pulse got=%b want=0", rvalid); end
    total++; if (rdata !== want) begin bad++; $display("FAIL byte_mask_hold got=%h want=%h", rdata, want); end
    exp_hold = want;
  endtask

  task automatic test_collision();
    logic [W*DW-1:0] want;
    we = 2'b10; waddr = 6'd9; wmask = '1; wdata = {MW{8'hAA}};
    model_write(we, waddr, wmask, wdata);
    step();
    ren = 1'b1; raddr = 6'd9; we = 2'b10; waddr = 6'd9; wdata = {MW{8'h55}}; wmask = 16'h00FF;
    model_write(we, waddr, wmask, wdata);
    step();
    idle_inputs();
    want = {{8{8'hAA}}, {8{8'h55}}, {DW{1'b0}}};
    total++; if (rdata !== want) begin bad++; $display("FAIL collision got=%h want=%h", rdata, want); end
    total++; if (rdata !== model_row(6'd9)) begin bad++; $display("FAIL collision_model got=%h want=%h", rdata, model_row(6'd9)); end
    exp_hold = want;
  endtask

  task automatic test_hold();
    logic [DW-1:0] x, y;
    logic [W*DW-1:0] held;
    x = rand_data(); y = rand_data();
    we = '1; waddr = 6'd3; wmask = '1; wdata = x;
    model_write(we, waddr, wmask, wdata);
    step();
    we = '0; ren = 1'b1; raddr = 6'd3;
    step();
    held = model_row(6'd3);
    total++; if (rdata !== held) begin bad++; $display("FAIL hold_first got=%h want=%h", rdata, held); end
    ren = 1'b0; we = '1; waddr = 6'd3; wmask = '1; wdata = y;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (rdata !== held || rvalid !== 1'b0) begin
        bad++; $display("FAIL hold cyc=%0d got=%h/%b want=%h/0", i, rdata, rvalid, held);
      end
    end
    model_write(we, waddr, wmask, wdata);
    we = '0; ren = 1'b1; raddr = 6'd3;
    step();
    ren = 1'b0;
    exp_hold = model_row(6'd3);
    total++; if (rdata !== {y, y}) begin bad++; $display("FAIL hold_after got=%h want=%h", rdata, {y, y}); end
  endtask

  // small address range forces frequent read/write collisions
  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      ren = 1'($urandom); raddr = AL'($urandom_range(0, 7));
      we = W'($urandom); waddr = AL'($urandom_range(0, 7));
      wmask = MW'($urandom); wdata = rand_data();
      model_write(we, waddr, wmask, wdata);
      if (ren) exp_hold = model_row(raddr);
      step();
      total++;
      if (rvalid !== ren || rdata !== exp_hold) begin
        bad++; $display("FAIL random cyc=%0d got=%h/%b want=%h/%b", i, rdata, rvalid, exp_hold, ren);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_init();
    int edges, valids;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (rdata !== '0 || rvalid !== 1'b0) begin bad++; $display("FAIL mid_reset_out got=%h/%b want=0/0", rdata, rvalid); end
    repeat (20) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (init_busy !== 1'b1) begin bad++; $display("FAIL mid_reset_busy got=%b want=1", init_busy); end
    wait_init(edges, valids);
    model_clear();
    total++; if (edges !== DEPTH) begin bad++; $display("FAIL mid_reset_length got=%0d want=%0d", edges, DEPTH); end
    total++; if (valids !== 0) begin bad++; $display("FAIL mid_reset_rvalid got=%0d want=0", valids); end
  endtask

  task automatic test_reset_ready();
    int edges, valids, errs;
    for (int i = 0; i < DEPTH; i++) begin
      we = '1; waddr = AL'(i); wmask = '1; wdata = rand_data() | 128'h1;
      step();
    end
    idle_inputs();
    ren = 1'b1; raddr = 6'd17;
    step();
    ren = 1'b0;
    total++; if (rdata == '0) begin bad++; $display("FAIL fill_check got=%h want=nonzero", rdata); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_init(edges, valids);
    model_clear();
    total++; if (edges !== DEPTH) begin bad++; $display("FAIL ready_reset_length got=%0d want=%0d", edges, DEPTH); end
    errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ren = 1'b1; raddr = AL'(i);
      step();
      if (rvalid !== 1'b1 || rdata !== model_row(AL'(i))) errs++;
    end
    ren = 1'b0;
    total++; if (errs !== 0) begin bad++; $display("FAIL ready_reset_clear got=%0d bad entries want=0", errs); end
  endtask

  initial begin
    model_clear();
    exp_hold = '0;
    test_reset();
    test_init_ignore();
    test_init_reads();
    test_byte_mask();
    test_collision();
    test_hold();
    test_random();
    test_reset_mid_init();
    test_reset_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
